// File: rtl/spi_target_pkg.sv
// spi_target_pkg: FSM states, command byte fields and word width shared by the SPI target register file
package spi_target_pkg;
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
    localparam int CMD_RD_BIT = 7;
    localparam int CMD_ADDR_MSB = 3;
    localparam int WORD_W = 32;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer for d with rise/fall detect against a third delay flop; q is the synchronized level
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] s;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s <= {3{RST_VAL}};
        else s <= {s[1:0], d};
    assign q = s[1];
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_target_regfile.sv
// spi_target_regfile: SPI mode-0 target; command byte then 32-bit words in/out of NREGS registers with address auto-increment
module spi_target_regfile
    import spi_target_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      spi_sck,
    input  logic                      spi_ss_n,
    input  logic                      spi_mosi,
    output logic                      spi_miso_o,
    output logic                      spi_miso_t,
    output logic [NREGS*WORD_W-1:0]   reg_q,
    input  logic [NREGS*WORD_W-1:0]   reg_rd,
    output logic                      wr_strobe,
    output logic [3:0]                wr_addr,
    output logic                      busy,
    output logic                      frame_err
);
    localparam int AW = $clog2(NREGS);
    state_t state;
    logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;
    logic [4:0] bit_cnt;
    logic [WORD_W-2:0] sh;
    logic [WORD_W-1:0] sh_nx, tx;
    logic [AW-1:0] addr, cmd_addr;
    logic [WORD_W-1:0] regs [NREGS];
    spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.clk(axi_aclk), .rst_n(axi_aresetn), .d(spi_sck), .q(), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_ss (.clk(axi_aclk), .rst_n(axi_aresetn), .d(spi_ss_n), .q(), .rise(ss_rise), .fall(ss_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(axi_aclk), .rst_n(axi_aresetn), .d(spi_mosi), .q(mosi_s), .rise(), .fall());
    assign sh_nx = {sh, mosi_s};
    assign cmd_addr = sh_nx[AW-1:0];
    assign busy = state != IDLE;
    assign spi_miso_t = ~busy;
    for (genvar i = 0; i < NREGS; i++) begin : g_q
        assign reg_q[i*WORD_W +: WORD_W] = regs[i];
    end
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state <= IDLE;
            bit_cnt <= '0;
            sh <= '0;
            tx <= '0;
            addr <= '0;
            spi_miso_o <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (ss_rise) begin
                frame_err <= state != IDLE && bit_cnt != 5'd0;
                state <= IDLE;
                bit_cnt <= '0;
                spi_miso_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (ss_fall) begin
                        state <= CMD;
                        bit_cnt <= '0;
                    end
                    CMD: if (sck_rise) begin
                        sh <= sh_nx[WORD_W-2:0];
                        bit_cnt <= bit_cnt == 5'd7 ? 5'd0 : bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            state <= sh_nx[CMD_RD_BIT] ? RDATA : WDATA;
                            addr <= sh_nx[CMD_RD_BIT] ? cmd_addr + 1'b1 : cmd_addr;
                            tx <= reg_rd[cmd_addr*WORD_W +: WORD_W];
                        end
                    end
                    WDATA: if (sck_rise) begin
                        sh <= sh_nx[WORD_W-2:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(WORD_W-1)) begin
                            regs[addr] <= sh_nx;
                            wr_strobe <= 1'b1;
                            wr_addr <= 4'(addr);
                            addr <= addr + 1'b1;
                        end
                    end
                    RDATA: if (sck_fall) begin
                        spi_miso_o <= tx[WORD_W-1];
                        tx <= {tx[WORD_W-2:0], 1'b0};
                    end else if (sck_rise) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(WORD_W-1)) begin
                            tx <= reg_rd[addr*WORD_W +: WORD_W];
                            addr <= addr + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
